hazard_flush_ctrl: RTL and testbench

//  Hazard/flush controller for the 5-stage pipeline: the block that drives the select (flush) and

---
 rtl/hazard_flush_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_flush_ctrl.sv
// Hazard/flush controller for the 5-stage pipeline: load-use stall, taken-branch flush and
// data-memory freeze, with saturating stall/flush performance counters.
module hazard_flush_ctrl #(
    parameter int REG_W      = 5,
    parameter int LOAD_STALL = 1,
    parameter int CW         = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic             idex_memread_i,
    input  logic             branch_taken_i,
    input  logic             dmem_busy_i,
    input  logic             perf_clr_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             pipe_hold_o,
    output logic             stalled_o,
    output logic [CW-1:0]    stall_cnt_o,
    output logic [CW-1:0]    flush_cnt_o
);

    typedef enum logic {RUN, LDSTALL} state_t;

    localparam logic [3:0]    LS_M1   = 4'(LOAD_STALL - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [CW-1:0] stall_cnt_reg, flush_cnt_reg;
    logic          hazard;
    logic          stall_inc, flush_inc;

    assign hazard = idex_memread_i && (idex_rt_i != '0) &&
                    ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Outputs are Mealy so the pipe registers react in the same cycle the event is seen.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (!rst_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (dmem_busy_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
        end else if (branch_taken_i) begin
            // The stalled load is younger than the branch, so its pending bubbles die with it.
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            flush_inc     = 1'b1;
            state_next    = RUN;
            cnt_next      = '0;
        end else if (state_reg == LDSTALL) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
            stall_inc    = 1'b1;
            cnt_next     = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
                state_next = RUN;
            end
        end else if (hazard) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
            stall_inc    = 1'b1;
            if (LOAD_STALL > 1) begin
                state_next = LDSTALL;
                cnt_next   = LS_M1;
            end
        end
    end

    assign stalled_o = rst_i && (state_reg == LDSTALL);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (perf_clr_i) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_inc && (stall_cnt_reg != CNT_MAX)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (flush_inc && (flush_cnt_reg != CNT_MAX)) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: a LOAD_STALL=1/CW=16 and a LOAD_STALL=3/CW=4 instance share
// stimulus; a bubble-owed model is compared every cycle, plus directed literal expectations.
module tb_hazard_flush_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
    logic       uses_rt = 1'b0, memread = 1'b0, br = 1'b0, busy = 1'b0, clr = 1'b0;

    // ctrl bits: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, hold, stalled}
    wire [6:0]  o1, o3;
    wire [15:0] sc1, fc1;
    wire [3:0]  sc3, fc3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    hazard_flush_ctrl #(.REG_W(5), .LOAD_STALL(1), .CW(16)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(uses_rt),
        .idex_rt_i(idex_rt), .idex_memread_i(memread),
        .branch_taken_i(br), .dmem_busy_i(busy), .perf_clr_i(clr),
        .pc_write_o(o1[6]), .ifid_write_o(o1[5]), .ifid_flush_o(o1[4]),
        .idex_flush_o(o1[3]), .exmem_flush_o(o1[2]), .pipe_hold_o(o1[1]),
        .stalled_o(o1[0]), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    hazard_flush_ctrl #(.REG_W(5), .LOAD_STALL(3), .CW(4)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(uses_rt),
        .idex_rt_i(idex_rt), .idex_memread_i(memread),
        .branch_taken_i(br), .dmem_busy_i(busy), .perf_clr_i(clr),
        .pc_write_o(o3[6]), .ifid_write_o(o3[5]), .ifid_flush_o(o3[4]),
        .idex_flush_o(o3[3]), .exmem_flush_o(o3[2]), .pipe_hold_o(o3[1]),
        .stalled_o(o3[0]), .stall_cnt_o(sc3), .flush_cnt_o(fc3)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        else n_pass++;
    endtask

    // Model: 'owed' is the number of bubbles still to be inserted after this cycle's decision.
    int owed1 = 0, owed3 = 0, msc1 = 0, mfc1 = 0, msc3 = 0, mfc3 = 0;

    function automatic logic hz_f();
        return memread && idex_rt != 0 && (idex_rt == ifid_rs || (uses_rt && idex_rt == ifid_rt));
    endfunction

    function automatic logic [6:0] exp_ctrl(input int owed);
        logic st;
        st = (owed > 0);
        if (!rst_i)             return 7'b0000000;
        if (busy)               return {6'b000001, st};
        if (br)                 return {6'b111110, st};
        if (owed > 0 || hz_f()) return {6'b000100, st};
        return {6'b110000, st};
    endfunction

    task automatic adv(input int ls, input int maxv, inout int owed, inout int sc, inout int fc);
        bit si, fi;
        si = 0; fi = 0;
        if (busy) begin
        end else if (br) begin
            fi = 1; owed = 0;
        end else if (owed > 0) begin
            si = 1; owed = owed - 1;
        end else if (hz_f()) begin
            si = 1; owed = ls - 1;
        end
        if (clr) begin
            sc = 0; fc = 0;
        end else begin
            if (si && sc < maxv) sc = sc + 1;
            if (fi && fc < maxv) fc = fc + 1;
        end
    endtask

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owed1 = 0; owed3 = 0; msc1 = 0; mfc1 = 0; msc3 = 0; mfc3 = 0;
        end else begin
            adv(1, 65535, owed1, msc1, mfc1);
            adv(3, 15, owed3, msc3, mfc3);
        end
    end

    always @(negedge clk_i) begin
        chk("ctrl1", 32'(o1), 32'(exp_ctrl(owed1)));
        chk("ctrl3", 32'(o3), 32'(exp_ctrl(owed3)));
        chk("cnt1", {sc1, fc1}, {16'(msc1), 16'(mfc1)});
        chk("cnt3", {24'd0, sc3, fc3}, {24'd0, 4'(msc3), 4'(mfc3)});
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set(input logic m, input logic [4:0] xrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic u, input logic b,
                       input logic bz, input logic c);
        memread = m; idex_rt = xrt; ifid_rs = rs; ifid_rt = rt; uses_rt = u;
        br = b; busy = bz; clr = c;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_pc_write", 32'(o1[6]), 32'd0);
        chk("rst_stall_cnt", 32'(sc1), 32'd0);
        rst_i = 1'b1;
        tick();
        #2 chk("idle_pc_write", 32'(o1[6]), 32'd1);

        // load-use hazard for one cycle
        set(1, 5, 5, 0, 0, 0, 0, 0);
        #2 chk("lu1_pc_write", 32'(o1[6]), 32'd0);
        chk("lu1_idex_flush", 32'(o1[3]), 32'd1);
        chk("lu3_c1_pc_write", 32'(o3[6]), 32'd0);
        chk("lu3_c1_stalled", 32'(o3[0]), 32'd0);
        tick();
        set(0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("lu1_resume", 32'(o1[6]), 32'd1);
        chk("lu1_stall_cnt", 32'(sc1), 32'd1);
        chk("lu3_c2_pc_write", 32'(o3[6]), 32'd0);
        chk("lu3_c2_stalled", 32'(o3[0]), 32'd1);
        tick();
        #2 chk("lu3_c3_pc_write", 32'(o3[6]), 32'd0);
        chk("lu3_c3_stalled", 32'(o3[0]), 32'd1);
        tick();
        #2 chk("lu3_resume", 32'(o3[6]), 32'd1);
        chk("lu3_stall_cnt", 32'(sc3), 32'd3);
        tick();

        // near-misses that must not stall
        set(1, 0, 0, 0, 1, 0, 0, 0);
        #2 chk("rt0_pc_write", {o1[6], o3[6]}, 32'd3);
        tick();
        set(1, 7, 3, 7, 0, 0, 0, 0);
        #2 chk("rtonly_pc_write", {o1[6], o3[6]}, 32'd3);
        tick();

        // taken branch on the last bubble cycle of a LOAD_STALL=3 stall
        set(0, 0, 0, 0, 0, 0, 0, 1); tick();
        set(1, 5, 5, 0, 0, 0, 0, 0); tick();
        set(0, 0, 0, 0, 0, 0, 0, 0); tick();
        set(0, 0, 0, 0, 0, 1, 0, 0);
        #2 chk("br_flushes", 32'(o3[4:2]), 32'd7);
        chk("br_pc_write", 32'(o3[6]), 32'd1);
        tick();
        set(0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("br_run_next", {o3[6], o3[0]}, 32'd2);
        chk("br_stall_cnt", 32'(sc3), 32'd2);
        chk("br_flush_cnt", 32'(fc3), 32'd1);
        tick();

        // memory busy freezes a pending stall for four cycles
        set(0, 0, 0, 0, 0, 0, 0, 1); tick();
        set(1, 5, 5, 0, 0, 0, 0, 0); tick();
        set(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            #2 chk("busy_hold", {o3[6], o3[1], o3[0]}, 32'd3);
            tick();
        end
        set(0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("busy_after1", 32'(o3[6]), 32'd0);
        tick();
        #2 chk("busy_after2", 32'(o3[6]), 32'd0);
        tick();
        #2 chk("busy_resume", 32'(o3[6]), 32'd1);
        chk("busy_stall_cnt", 32'(sc3), 32'd3);
        tick();

        // saturation of the 4-bit counter, then clear wins over increment
        set(0, 0, 0, 0, 0, 0, 0, 1); tick();
        set(1, 5, 5, 0, 0, 0, 0, 0);
        repeat (17) tick();
        #2 chk("sat_stall_cnt", 32'(sc3), 32'd15);
        set(1, 5, 5, 0, 0, 0, 0, 1); tick();
        #2 chk("clr_stall_cnt", 32'(sc3), 32'd0);
        set(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // reset asserted mid-stall
        set(1, 5, 5, 0, 0, 0, 0, 0); tick();
        set(0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("pre_rst_stalled", 32'(o3[0]), 32'd1);
        rst_i = 1'b0;
        #1 chk("rst_mid_ctrl", 32'(o3), 32'd0);
        chk("rst_mid_stall_cnt", 32'(sc3), 32'd0);
        tick();
        rst_i = 1'b1;
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            memread = 1'($urandom_range(0, 1));
            idex_rt = 5'($urandom_range(0, 3));
            ifid_rs = 5'($urandom_range(0, 3));
            ifid_rt = 5'($urandom_range(0, 3));
            uses_rt = 1'($urandom_range(0, 1));
            br      = ($urandom_range(0, 7) == 0);
            busy    = ($urandom_range(0, 5) == 0);
            clr     = !busy && ($urandom_range(0, 49) == 0);
            rst_i   = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_i = 1'b1;
        tick();
        @(negedge clk_i);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
